seven_segment_scanner: RTL and testbench
========================================

SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

Interface
REQ-001 The module SHALL expose parameter PRESCALE, default 1000, clock cycles per digit slot (legal range 8..65535).
REQ-002 The module SHALL expose parameter BLANK, default 4, leading blank cycles per slot (legal range 1..PRESCALE-4).
REQ-003 The module SHALL have port clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The module SHALL have ports display1..display8  input  8 each  segment patterns {a,b,c,d,e,f,g,dp}, bit7=a, 1=lit.
REQ-006 The module SHALL have port load  input  1  single-cycle strobe capturing display1..8 and brightness.
REQ-007 The module SHALL have port brightness  input  2  on-time level 0 (dimmest) .. 3 (brightest).
REQ-008 The module SHALL have port seg_out  output  8  registered segment drive, 1=lit.
REQ-009 The module SHALL have port digit_en  output  8  registered one-hot digit enable, bit0=display1, 1=on.
REQ-010 The module SHALL have port frame_done  output  1  one-cycle pulse at each frame boundary.
REQ-011 The module SHALL have port pending  output  1  high while captured data awaits the next frame boundary.

Function
REQ-012 Slot counter SHALL count 0..PRESCALE-1, wrap to 0; digit index SHALL advance 0..7 on each slot wrap, wrap 7->0.
REQ-013 Frame boundary SHALL be the cycle where slot counter = PRESCALE-1 and digit index = 7.
REQ-014 Active on-window SHALL be W = ((PRESCALE-BLANK) >> 2) * (active_brightness + 1) cycles.
REQ-015 Per-slot states SHALL be BLANK (count < BLANK), ON (BLANK <= count < BLANK+W), OFF (remaining cycles).
REQ-016 In BLANK and OFF, seg_out and digit_en SHALL be 0; in ON, digit_en SHALL be one-hot at the current index and seg_out SHALL be that digit's active pattern.
REQ-017 Outputs SHALL be registered: the output value reflects the state of the counter value one cycle earlier (latency 1).
REQ-018 load SHALL copy display1..8 and brightness into a pending buffer and set pending on the next edge.
REQ-019 load while pending=1 SHALL overwrite the pending buffer; the latest load wins.
REQ-020 At a frame boundary with pending=1, the pending buffer SHALL move to the active registers and pending SHALL clear on the same edge.
REQ-021 load coincident with a frame boundary SHALL transfer the previously pending data (if any); the new data SHALL be captured into the buffer and pending SHALL be 1 afterwards.
REQ-022 frame_done SHALL pulse for exactly one cycle per frame boundary, regardless of pending.
REQ-023 Active patterns and brightness SHALL change only at frame boundaries; a frame never shows mixed data.

Reset
REQ-024 While reset=1 on an edge: slot counter=0, digit index=0, active and pending buffers=0, active_brightness=3, pending=0, seg_out=0, digit_en=0, frame_done=0.
REQ-025 Reset SHALL take priority over load and over any frame-boundary transfer, including mid-slot and mid-frame.
REQ-026 After reset release, scanning SHALL restart at digit index 0, slot count 0 in BLANK.

Verification (PRESCALE=8, BLANK=2, so W=b+1)
REQ-027 Reset, no load -> digit_en cycles 0x01..0x80 in ON windows of 4 cycles, seg_out=0x00, frame_done every 64 cycles.
REQ-028 load with display1=0xFC, others 0x60, brightness=3 -> pending=1 until boundary; the next frame shows seg_out=0xFC with digit_en=0x01 and 0x60 elsewhere; pending clears with frame_done.
REQ-029 brightness=0 loaded -> per slot: 2 blank, 1 ON, 5 OFF cycles; digit_en never has two bits set.
REQ-030 Two loads (0x11, then 0x22) within one frame -> only 0x22 displayed after the boundary; 0x11 never appears.
REQ-031 load asserted exactly on a boundary cycle with pending=0 -> active unchanged in that frame, pending=1, new data shown from the following frame.
REQ-032 Reset asserted mid-ON of digit 5 -> next cycle seg_out=0, digit_en=0, pending=0; the scan restarts at digit_en=0x01 after BLANK.

Source files
------------

// File: rtl/seven_segment_scanner.sv
// ============================================================================
// Module   : seven_segment_scanner
// Purpose  : 8-digit multiplexed seven-segment scanner with frame-synchronous
//            double-buffered patterns and PWM-style brightness control.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_segment_scanner #(
    parameter int PRESCALE = 1000,
    parameter int BLANK    = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] display1,
    input  logic [7:0] display2,
    input  logic [7:0] display3,
    input  logic [7:0] display4,
    input  logic [7:0] display5,
    input  logic [7:0] display6,
    input  logic [7:0] display7,
    input  logic [7:0] display8,
    input  logic       load,
    input  logic [1:0] brightness,
    output logic [7:0] seg_out,
    output logic [7:0] digit_en,
    output logic       frame_done,
    output logic       pending
);

    localparam int              C_CW      = $clog2(PRESCALE);
    localparam logic [C_CW-1:0] C_LAST    = C_CW'(PRESCALE - 1);
    localparam logic [17:0]     C_QUARTER = 18'((PRESCALE - BLANK) >> 2);
    localparam logic [17:0]     C_BLANK   = 18'(BLANK);

    logic [C_CW-1:0]  cnt_q;
    logic [C_CW-1:0]  cnt_d;
    logic [2:0]       idx_q;
    logic [2:0]       idx_d;
    logic [7:0][7:0]  act_q;
    logic [7:0][7:0]  act_d;
    logic [7:0][7:0]  pend_q;
    logic [7:0][7:0]  pend_d;
    logic [1:0]       act_bri_q;
    logic [1:0]       act_bri_d;
    logic [1:0]       pend_bri_q;
    logic [1:0]       pend_bri_d;
    logic             pending_q;
    logic             pending_d;
    logic [7:0]       seg_q;
    logic [7:0]       seg_d;
    logic [7:0]       dig_q;
    logic [7:0]       dig_d;
    logic             fdone_q;

    logic [7:0][7:0]  w_disp;
    logic [17:0]      w_on_len;
    logic [17:0]      w_cnt_ext;
    logic             w_slot_on;
    logic             w_slot_wrap;
    logic             w_boundary;

    // Element [0] is display1 so the digit index selects its pattern directly.
    assign w_disp = {display8, display7, display6, display5,
                     display4, display3, display2, display1};

    assign w_on_len    = C_QUARTER * (18'(act_bri_q) + 18'd1);
    assign w_cnt_ext   = 18'(cnt_q);
    assign w_slot_on   = (w_cnt_ext >= C_BLANK) && (w_cnt_ext < C_BLANK + w_on_len);
    assign w_slot_wrap = (cnt_q == C_LAST);
    assign w_boundary  = w_slot_wrap && (idx_q == 3'd7);

    always_comb begin
        cnt_d      = w_slot_wrap ? '0 : cnt_q + 1'b1;
        idx_d      = w_slot_wrap ? idx_q + 3'd1 : idx_q;
        act_d      = act_q;
        act_bri_d  = act_bri_q;
        pend_d     = pend_q;
        pend_bri_d = pend_bri_q;
        pending_d  = pending_q;

        // The transfer uses the buffer as it stood before this edge, so a load
        // landing on the boundary waits for the following frame.
        if (w_boundary && pending_q) begin
            act_d     = pend_q;
            act_bri_d = pend_bri_q;
            pending_d = 1'b0;
        end
        if (load) begin
            pend_d     = w_disp;
            pend_bri_d = brightness;
            pending_d  = 1'b1;
        end

        seg_d = 8'h00;
        dig_d = 8'h00;
        if (w_slot_on) begin
            seg_d = act_q[idx_q];
            dig_d = 8'h01 << idx_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q      <= '0;
            idx_q      <= 3'd0;
            act_q      <= '0;
            pend_q     <= '0;
            act_bri_q  <= 2'd3;
            pend_bri_q <= 2'd0;
            pending_q  <= 1'b0;
            seg_q      <= 8'h00;
            dig_q      <= 8'h00;
            fdone_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            act_q      <= act_d;
            pend_q     <= pend_d;
            act_bri_q  <= act_bri_d;
            pend_bri_q <= pend_bri_d;
            pending_q  <= pending_d;
            seg_q      <= seg_d;
            dig_q      <= dig_d;
            fdone_q    <= w_boundary;
        end
    end

    assign seg_out    = seg_q;
    assign digit_en   = dig_q;
    assign frame_done = fdone_q;
    assign pending    = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_seven_segment_scanner.sv
// ============================================================================
// Module   : tb_seven_segment_scanner
// Purpose  : Randomized and directed stimulus for seven_segment_scanner,
//            compared cycle by cycle against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seven_segment_scanner;

    localparam int P  = 8;
    localparam int B  = 2;
    localparam int FR = 8 * P;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] disp [8];
    logic       load = 1'b0;
    logic [1:0] brightness = 2'd0;
    logic [7:0] seg_out;
    logic [7:0] digit_en;
    logic       frame_done;
    logic       pending;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: time since reset plus the two data buffers.
    int         mt;
    logic [7:0] m_act  [8];
    logic [7:0] m_pend [8];
    logic [1:0] m_actb;
    logic [1:0] m_pendb;
    logic       m_pf;

    seven_segment_scanner #(.PRESCALE(P), .BLANK(B)) u_dut (
        .clock      (clock),
        .reset      (reset),
        .display1   (disp[0]),
        .display2   (disp[1]),
        .display3   (disp[2]),
        .display4   (disp[3]),
        .display5   (disp[4]),
        .display6   (disp[5]),
        .display7   (disp[6]),
        .display8   (disp[7]),
        .load       (load),
        .brightness (brightness),
        .seg_out    (seg_out),
        .digit_en   (digit_en),
        .frame_done (frame_done),
        .pending    (pending)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (model t=%0d)", tag, got, exp, mt);
        end
    endtask

    task automatic step();
        int pos, cnt, idx, w;
        logic [7:0] es, ed;
        logic       ef;
        @(posedge clock);
        if (reset) begin
            mt = 0; m_pf = 1'b0; m_actb = 2'd3; m_pendb = 2'd0;
            for (int i = 0; i < 8; i++) begin m_act[i] = 8'h00; m_pend[i] = 8'h00; end
            es = 8'h00; ed = 8'h00; ef = 1'b0;
        end else begin
            pos = mt % FR;
            idx = pos / P;
            cnt = pos % P;
            w   = ((P - B) / 4) * (int'(m_actb) + 1);
            if (cnt >= B && cnt < B + w) begin
                es = m_act[idx];
                ed = 8'(1 << idx);
            end else begin
                es = 8'h00;
                ed = 8'h00;
            end
            ef = (pos == FR - 1);
            if (ef && m_pf) begin
                m_act  = m_pend;
                m_actb = m_pendb;
                m_pf   = 1'b0;
            end
            if (load) begin
                for (int i = 0; i < 8; i++) m_pend[i] = disp[i];
                m_pendb = brightness;
                m_pf    = 1'b1;
            end
            mt++;
        end
        #1;
        check("seg_out", 32'(seg_out), 32'(es));
        check("digit_en", 32'(digit_en), 32'(ed));
        check("frame_done", 32'(frame_done), 32'(ef));
        check("pending", 32'(pending), 32'(m_pf));
        check("onehot", 32'($countones(digit_en) <= 1), 32'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_load(input logic [7:0] first, input logic [7:0] rest, input logic [1:0] b);
        disp[0] = first;
        for (int i = 1; i < 8; i++) disp[i] = rest;
        brightness = b;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic wait_pos(input int target);
        int k;
        k = 0;
        while ((mt % FR) != target && k < 4 * FR) begin
            step();
            k++;
        end
        check("wait_pos_timeout", 32'(k < 4 * FR), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) disp[i] = 8'h00;
        mt = 0;
        run(3);
        reset = 1'b0;
        run(2 * FR + 2);

        pulse_load(8'hFC, 8'h60, 2'd3);
        run(2 * FR);

        pulse_load(8'hA5, 8'h3C, 2'd0);
        run(2 * FR);

        wait_pos(5);
        pulse_load(8'h11, 8'h11, 2'd2);
        run(10);
        pulse_load(8'h22, 8'h22, 2'd2);
        run(2 * FR);

        wait_pos(FR - 1);
        pulse_load(8'h5A, 8'hC3, 2'd1);
        run(2 * FR);

        // Reset in the middle of digit 5's on-window, with data pending.
        pulse_load(8'h77, 8'h88, 2'd3);
        wait_pos(5 * P + 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        run(FR + 4);

        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                for (int j = 0; j < 8; j++) disp[j] = 8'($urandom);
                brightness = 2'($urandom);
                load = 1'b1;
            end
            if ($urandom_range(0, 999) == 0) reset = 1'b1;
            step();
            load  = 1'b0;
            reset = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
